axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one downstream AXI4 read port (AR/R) between NUM_M upstream read masters.
//  Round-robin arbitration on AR; winner index prepended to ARID; R beats routed back by ID MSBs.
//  Per-master outstanding-burst limit. Sits between master agents/DUT ports and a crossbar slave port.
//  AR sidebands lock/cache/prot/qos/region/user are not carried; the wrapper ties them off.
// PARAMETERS
//  NUM_M      4   number of upstream masters (>=2)
//  AXI_ADDR_W 8   address width
//  AXI_DATA_W 8   data width
//  AXI_ID_W   8   upstream ID width
//  MAX_OUTST  4   max outstanding read bursts per master (>=1)
//  (local) MIDX_W = $clog2(NUM_M); OUT_ID_W = AXI_ID_W+MIDX_W; CNT_W = $clog2(MAX_OUTST+1)
// PORTS
//  aclk       in   1                 clock, all logic on posedge
//  aresetn    in   1                 async active-low reset
//  s_arvalid  in   NUM_M             per-master AR valid
//  s_arready  out  NUM_M             per-master AR ready (one-hot or zero)
//  s_araddr   in   NUM_M*AXI_ADDR_W  flattened, master k at [k*W +: W]; same for s_arlen/s_arsize/s_arburst/s_arid
//  s_arlen    in   NUM_M*8 | s_arsize in NUM_M*3 | s_arburst in NUM_M*2 | s_arid in NUM_M*AXI_ID_W
//  s_rvalid   out  NUM_M             per-master R valid
//  s_rready   in   NUM_M             per-master R ready
//  s_rid      out  AXI_ID_W          shared R id (low bits of m_rid)
//  s_rdata    out  AXI_DATA_W | s_rresp out 2 | s_rlast out 1   shared R payload, broadcast
//  m_arvalid  out  1 | m_arready in 1 | m_araddr out AXI_ADDR_W | m_arlen 8 | m_arsize 3 | m_arburst 2
//  m_arid     out  OUT_ID_W          {winner index, s_arid}
//  m_rvalid   in   1 | m_rready out 1 | m_rid in OUT_ID_W | m_rdata in AXI_DATA_W | m_rresp in 2 | m_rlast in 1
//  rsp_err    out  1                 sticky: R beat with bad index or rlast with zero outstanding
// BEHAVIOUR
//  Reset: s_arready=0, m_arvalid=0, m_ar* payload=0, all counters=0, rr_ptr=NUM_M-1 (master 0 wins first), rsp_err=0.
//  Reset mid-burst drops all state; no replay.
//  Eligibility: eligible[k] = s_arvalid[k] && cnt[k] < MAX_OUTST.
//  AR slot is one output register: EMPTY / FULL (m_arvalid = FULL).
//  Grant when slot EMPTY, or FULL with m_arready this cycle (back-to-back).
//  Grant picks the first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_M.
//  Grant cycle: s_arready[k]=1 (combinational, this cycle only).
//  Next edge: payload and {k,s_arid[k]} latched into m_ar*, slot FULL, rr_ptr<=k, cnt[k]++.
//  Latency s_arvalid -> m_arvalid: 1 cycle. Throughput: 1 AR/cycle while m_arready stays high.
//  FULL with m_arready=0: m_ar* held stable, no grant, s_arready=0.
//  m_arvalid && m_arready with no eligible master: slot -> EMPTY.
//  R routing (combinational, 0 latency): idx = m_rid[OUT_ID_W-1 -: MIDX_W].
//  s_rvalid[idx]=m_rvalid; m_rready=s_rready[idx]; s_rid=m_rid[AXI_ID_W-1:0]; rdata/rresp/rlast broadcast.
//  idx >= NUM_M (non-power-of-2 NUM_M): beat sunk (m_rready=1), no s_rvalid, rsp_err<=1.
//  m_rvalid && m_rready && m_rlast: cnt[idx]--.
//  Decrement at cnt==0: cnt held at 0, rsp_err<=1.
//  Same-master grant and last-beat completion in one cycle: cnt unchanged.
//  Master at MAX_OUTST: skipped by arbitration; re-eligible the cycle after its cnt drops.
//  No ordering enforcement across masters; the slave interleaves by ID freely.
// TESTING
//  1 Reset, NUM_M=4, all s_arvalid=1, m_arready=1 -> grants 0,1,2,3,0 on consecutive cycles; m_arid MSBs 0,1,2,3,0.
//  2 Only master 2 valid, araddr=0x40, arid=0x05, m_arready low 3 cycles -> m_arid=0x205, payload stable 3 cycles, s_arready[2] one cycle only.
//  3 Master 1 issues 4 ARs, no R returned, MAX_OUTST=4 -> 5th AR not granted.
//    One rlast beat for id 0x1xx -> master 1 granted the next eligible cycle.
//  4 m_rvalid with m_rid=0x3A7, s_rready[3]=0 -> s_rvalid=4'b1000, s_rid=0xA7, m_rready=0.
//    Set s_rready[3]=1 -> handshake.
//  5 Master 0 grant coincides with master 0 rlast handshake, cnt[0]=2 -> cnt[0] stays 2.
//  6 rlast for master 2 with cnt[2]=0 -> cnt stays 0, rsp_err=1 until reset.
//    Drop aresetn mid-burst -> m_arvalid=0 and counters 0 asynchronously.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR/R) among NUM_M read masters.
// The winner index is prepended to ARID, and R beats are routed back using the upper ID bits.
module axi_rd_arbiter #(
   parameter  int NUM_M      = 4,
   parameter  int AXI_ADDR_W = 8,
   parameter  int AXI_DATA_W = 8,
   parameter  int AXI_ID_W   = 8,
   parameter  int MAX_OUTST  = 4,
   localparam int MIDX_W     = $clog2(NUM_M),
   localparam int OUT_ID_W   = AXI_ID_W + MIDX_W,
   localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   // upstream AR
   input  logic [NUM_M-1:0]              s_arvalid,
   output logic [NUM_M-1:0]              s_arready,
   input  logic [NUM_M*AXI_ADDR_W-1:0]   s_araddr,
   input  logic [NUM_M*8-1:0]            s_arlen,
   input  logic [NUM_M*3-1:0]            s_arsize,
   input  logic [NUM_M*2-1:0]            s_arburst,
   input  logic [NUM_M*AXI_ID_W-1:0]     s_arid,
   // upstream R
   output logic [NUM_M-1:0]              s_rvalid,
   input  logic [NUM_M-1:0]              s_rready,
   output logic [AXI_ID_W-1:0]           s_rid,
   output logic [AXI_DATA_W-1:0]         s_rdata,
   output logic [1:0]                    s_rresp,
   output logic                          s_rlast,
   // downstream AR
   output logic                          m_arvalid,
   input  logic                          m_arready,
   output logic [AXI_ADDR_W-1:0]         m_araddr,
   output logic [7:0]                    m_arlen,
   output logic [2:0]                    m_arsize,
   output logic [1:0]                    m_arburst,
   output logic [OUT_ID_W-1:0]           m_arid,
   // downstream R
   input  logic                          m_rvalid,
   output logic                          m_rready,
   input  logic [OUT_ID_W-1:0]           m_rid,
   input  logic [AXI_DATA_W-1:0]         m_rdata,
   input  logic [1:0]                    m_rresp,
   input  logic                          m_rlast,
   output logic                          rsp_err
);

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   slot_e                  slot_q, slot_d;
   logic [MIDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                   rsp_err_q, rsp_err_d;

   logic [AXI_ADDR_W-1:0]  ar_addr_q;
   logic [7:0]             ar_len_q;
   logic [2:0]             ar_size_q;
   logic [1:0]             ar_burst_q;
   logic [OUT_ID_W-1:0]    ar_id_q;

   logic [NUM_M-1:0]       eligible;
   logic [NUM_M-1:0]       gnt_oh;
   logic [NUM_M-1:0]       dec_oh;
   logic [NUM_M-1:0]       underflow;
   logic [MIDX_W-1:0]      cand;
   logic [MIDX_W-1:0]      gnt_idx;
   logic                   gnt_found;
   logic                   slot_can_take;
   logic                   grant;

   logic [AXI_ADDR_W-1:0]  sel_addr;
   logic [7:0]             sel_len;
   logic [2:0]             sel_size;
   logic [1:0]             sel_burst;
   logic [AXI_ID_W-1:0]    sel_id;

   logic [MIDX_W-1:0]      r_idx;
   logic                   r_idx_ok;
   logic                   r_last_hs;
   logic                   r_bad_beat;

   // ------------------------------------------------------------------
   // Round-robin search starting just after the previous winner
   // ------------------------------------------------------------------
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = rr_ptr_q;
      cand      = rr_ptr_q;
      for (int i = 1; i <= NUM_M; i++) begin
         cand = MIDX_W'((int'(rr_ptr_q) + i) % NUM_M);
         if (!gnt_found && eligible[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Suppressing grants while reset is held keeps s_arready low during reset.
   assign slot_can_take = (slot_q == SLOT_EMPTY) || m_arready;
   assign grant         = aresetn && slot_can_take && gnt_found;

   // Winner payload mux
   always_comb begin
      sel_addr  = '0;
      sel_len   = '0;
      sel_size  = '0;
      sel_burst = '0;
      sel_id    = '0;
      for (int k = 0; k < NUM_M; k++) begin
         if (gnt_idx == MIDX_W'(k)) begin
            sel_addr  = s_araddr[k*AXI_ADDR_W +: AXI_ADDR_W];
            sel_len   = s_arlen[k*8 +: 8];
            sel_size  = s_arsize[k*3 +: 3];
            sel_burst = s_arburst[k*2 +: 2];
            sel_id    = s_arid[k*AXI_ID_W +: AXI_ID_W];
         end
      end
   end

   // ------------------------------------------------------------------
   // AR output slot: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         slot_q   <= SLOT_EMPTY;
         rr_ptr_q <= MIDX_W'(NUM_M - 1);
      end else begin
         slot_q   <= slot_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      slot_d   = slot_q;
      rr_ptr_d = rr_ptr_q;
      case (slot_q)
         SLOT_EMPTY: begin
            if (grant) begin
               slot_d   = SLOT_FULL;
               rr_ptr_d = gnt_idx;
            end
         end
         SLOT_FULL: begin
            if (grant) begin
               rr_ptr_d = gnt_idx;
            end else if (m_arready) begin
               slot_d = SLOT_EMPTY;
            end
         end
         default: slot_d = SLOT_EMPTY;
      endcase
   end

   always_comb begin
      m_arvalid = (slot_q == SLOT_FULL);
      s_arready = '0;
      if (grant) begin
         s_arready = gnt_oh;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         ar_id_q    <= '0;
      end else if (grant) begin
         ar_addr_q  <= sel_addr;
         ar_len_q   <= sel_len;
         ar_size_q  <= sel_size;
         ar_burst_q <= sel_burst;
         ar_id_q    <= {gnt_idx, sel_id};
      end
   end

   assign m_araddr  = ar_addr_q;
   assign m_arlen   = ar_len_q;
   assign m_arsize  = ar_size_q;
   assign m_arburst = ar_burst_q;
   assign m_arid    = ar_id_q;

   // ------------------------------------------------------------------
   // R routing by the upper ID bits; indices beyond NUM_M are sunk
   // ------------------------------------------------------------------
   assign r_idx    = m_rid[OUT_ID_W-1 -: MIDX_W];
   assign r_idx_ok = ({1'b0, r_idx} < (MIDX_W+1)'(NUM_M));

   always_comb begin
      s_rvalid = '0;
      m_rready = 1'b1;
      if (r_idx_ok) begin
         s_rvalid[r_idx] = m_rvalid;
         m_rready        = s_rready[r_idx];
      end
   end

   assign s_rid   = m_rid[AXI_ID_W-1:0];
   assign s_rdata = m_rdata;
   assign s_rresp = m_rresp;
   assign s_rlast = m_rlast;

   assign r_last_hs  = m_rvalid && m_rready && m_rlast && r_idx_ok;
   assign r_bad_beat = m_rvalid && !r_idx_ok;

   // ------------------------------------------------------------------
   // Per-master outstanding-burst counters
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign gnt_oh[gi]    = (gnt_idx == MIDX_W'(gi));
      assign dec_oh[gi]    = r_last_hs && (r_idx == MIDX_W'(gi));
      assign eligible[gi]  = s_arvalid[gi] && (cnt_q < CNT_W'(MAX_OUTST));
      // A completion with nothing outstanding is a protocol error even if a
      // grant lands in the same cycle, since that burst is not downstream yet.
      assign underflow[gi] = dec_oh[gi] && (cnt_q == '0);

      always_comb begin
         cnt_d = cnt_q;
         if (grant && gnt_oh[gi] && !dec_oh[gi]) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else if (dec_oh[gi] && !(grant && gnt_oh[gi]) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Sticky response error
   // ------------------------------------------------------------------
   assign rsp_err_d = rsp_err_q || r_bad_beat || (|underflow);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of grants and outstanding bursts.
module tb_axi_rd_arbiter;

   localparam int NM = 4;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  s_arvalid, s_arready;
   logic [31:0] s_araddr;
   logic [31:0] s_arlen;
   logic [11:0] s_arsize;
   logic [7:0]  s_arburst;
   logic [31:0] s_arid;
   logic [3:0]  s_rvalid, s_rready;
   logic [7:0]  s_rid, s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rlast;
   logic        m_arvalid, m_arready;
   logic [7:0]  m_araddr, m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic [9:0]  m_arid;
   logic        m_rvalid, m_rready;
   logic [9:0]  m_rid;
   logic [7:0]  m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   axi_rd_arbiter dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast),
      .rsp_err(rsp_err)
   );

   always #5 aclk = ~aclk;

   task automatic drive_idle();
      s_arvalid = '0;
      s_araddr  = '0;
      s_arlen   = '0;
      s_arsize  = '0;
      s_arburst = '0;
      s_arid    = '0;
      s_rready  = '0;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rid     = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rlast   = 1'b0;
   endtask

   task automatic apply_reset();
      drive_idle();
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b want=0", m_arvalid); end
      total++; if (s_arready !== 4'b0) begin bad++; $display("FAIL reset_arready got=%b want=0000", s_arready); end
      total++; if (m_arid !== 10'h0 || m_araddr !== 8'h0 || m_arlen !== 8'h0) begin
         bad++; $display("FAIL reset_payload id=%h addr=%h len=%h want all 0", m_arid, m_araddr, m_arlen);
      end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
      $display("test_reset done");
   endtask

   task automatic test_round_robin();
      int exp_k;
      apply_reset();
      s_arvalid = 4'hF;
      m_arready = 1'b1;
      for (int k = 0; k < NM; k++) begin
         s_araddr[k*8 +: 8] = 8'(8'h10 * k + 1);
         s_arlen[k*8 +: 8]  = 8'(k + 3);
         s_arid[k*8 +: 8]   = 8'(k + 8'hA0);
      end
      for (int n = 0; n < 5; n++) begin
         exp_k = n % NM;
         #1;
         total++; if (s_arready !== 4'(1 << exp_k)) begin
            bad++; $display("FAIL rr_grant n=%0d got=%b want=%b", n, s_arready, 4'(1 << exp_k));
         end
         @(negedge aclk);
         total++; if (m_arvalid !== 1'b1 || m_arid !== {2'(exp_k), 8'(exp_k + 8'hA0)} ||
                      m_araddr !== 8'(8'h10 * exp_k + 1) || m_arlen !== 8'(exp_k + 3)) begin
            bad++; $display("FAIL rr_payload n=%0d vld=%b id=%h addr=%h len=%h want id=%h", n,
                            m_arvalid, m_arid, m_araddr, m_arlen, {2'(exp_k), 8'(exp_k + 8'hA0)});
         end
         $display("rr grant n=%0d master=%0d m_arid=%h", n, exp_k, m_arid);
      end
      drive_idle();
   endtask

   task automatic test_hold_stable();
      apply_reset();
      s_arvalid          = 4'b0100;
      s_araddr[16 +: 8]  = 8'h40;
      s_arid[16 +: 8]    = 8'h05;
      m_arready          = 1'b0;
      #1;
      total++; if (s_arready !== 4'b0100) begin bad++; $display("FAIL hold_first_grant got=%b want=0100", s_arready); end
      @(negedge aclk);
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (m_arvalid !== 1'b1 || m_arid !== 10'h205 || m_araddr !== 8'h40) begin
            bad++; $display("FAIL hold_payload c=%0d vld=%b id=%h addr=%h want 1/205/40", c, m_arvalid, m_arid, m_araddr);
         end
         total++; if (s_arready !== 4'b0) begin bad++; $display("FAIL hold_no_grant c=%0d got=%b want=0000", c, s_arready); end
         @(negedge aclk);
      end
      m_arready = 1'b1;
      #1;
      total++; if (s_arready !== 4'b0100) begin bad++; $display("FAIL hold_b2b_grant got=%b want=0100", s_arready); end
      @(negedge aclk);
      $display("hold: m_arid=%h held 3 cycles then back-to-back grant", m_arid);
      drive_idle();
   endtask

   task automatic test_outst_limit();
      apply_reset();
      s_arvalid        = 4'b0010;
      s_arid[8 +: 8]   = 8'h33;
      m_arready        = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #1;
         total++; if (s_arready !== 4'b0010) begin bad++; $display("FAIL outst_grant n=%0d got=%b want=0010", n, s_arready); end
         @(negedge aclk);
      end
      m_rvalid = 1'b1;
      m_rid    = 10'h133;
      m_rlast  = 1'b1;
      s_rready = 4'b0010;
      #1;
      total++; if (s_arready !== 4'b0) begin bad++; $display("FAIL outst_blocked got=%b want=0000", s_arready); end
      total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL outst_rready got=%b want=1", m_rready); end
      @(negedge aclk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      #1;
      total++; if (s_arready !== 4'b0010) begin bad++; $display("FAIL outst_regrant got=%b want=0010", s_arready); end
      @(negedge aclk);
      $display("outst: master 1 blocked at 4, regranted after rlast");
      drive_idle();
   endtask

   task automatic test_r_route();
      apply_reset();
      m_rvalid = 1'b1;
      m_rid    = 10'h3A7;
      m_rdata  = 8'h5C;
      m_rresp  = 2'b10;
      m_rlast  = 1'b0;
      s_rready = 4'b0111;
      #1;
      total++; if (s_rvalid !== 4'b1000 || s_rid !== 8'hA7 || m_rready !== 1'b0) begin
         bad++; $display("FAIL route_stall rvalid=%b rid=%h rready=%b want 1000/a7/0", s_rvalid, s_rid, m_rready);
      end
      total++; if (s_rdata !== 8'h5C || s_rresp !== 2'b10 || s_rlast !== 1'b0) begin
         bad++; $display("FAIL route_payload data=%h resp=%b last=%b want 5c/10/0", s_rdata, s_rresp, s_rlast);
      end
      s_rready = 4'b1000;
      #1;
      total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL route_hs got=%b want=1", m_rready); end
      @(negedge aclk);
      drive_idle();
      #1;
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL route_no_err got=%b want=0", rsp_err); end
      $display("route: rid=3a7 delivered to master 3");
   endtask

   task automatic test_same_cycle();
      int grants;
      apply_reset();
      s_arvalid = 4'b0001;
      m_arready = 1'b1;
      repeat (2) @(negedge aclk);
      m_rvalid = 1'b1;
      m_rid    = 10'h011;
      m_rlast  = 1'b1;
      s_rready = 4'b0001;
      #1;
      total++; if (s_arready !== 4'b0001 || m_rready !== 1'b1) begin
         bad++; $display("FAIL same_cycle_hs arready=%b rready=%b want 0001/1", s_arready, m_rready);
      end
      @(negedge aclk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      grants = 0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (s_arready[0] === 1'b1) grants++;
         @(negedge aclk);
      end
      total++; if (grants != 2) begin bad++; $display("FAIL same_cycle_cnt extra_grants=%0d want=2", grants); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL same_cycle_err got=%b want=0", rsp_err); end
      $display("same_cycle: extra grants after coincident grant/rlast=%0d", grants);
      drive_idle();
   endtask

   task automatic test_rsp_err_and_async_reset();
      int grants;
      apply_reset();
      m_rvalid = 1'b1;
      m_rid    = 10'h211;
      m_rlast  = 1'b1;
      s_rready = 4'b0100;
      @(negedge aclk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL err_sticky c=%0d got=%b want=1", c, rsp_err); end
         @(negedge aclk);
      end
      s_arvalid = 4'b0001;
      s_arid[0 +: 8] = 8'h77;
      @(negedge aclk);
      s_arvalid = 4'b0000;
      #1;
      total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL err_midburst_vld got=%b want=1", m_arvalid); end
      #1;
      aresetn = 1'b0;
      #1;
      total++; if (m_arvalid !== 1'b0 || rsp_err !== 1'b0 || m_arid !== 10'h0) begin
         bad++; $display("FAIL async_reset vld=%b err=%b id=%h want 0/0/000", m_arvalid, rsp_err, m_arid);
      end
      @(negedge aclk);
      aresetn   = 1'b1;
      s_arvalid = 4'b0001;
      m_arready = 1'b1;
      grants    = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (s_arready[0] === 1'b1) grants++;
         @(negedge aclk);
      end
      total++; if (grants != 4) begin bad++; $display("FAIL async_reset_cnt grants=%0d want=4", grants); end
      $display("rsp_err: sticky until async reset; %0d grants after reset", grants);
      drive_idle();
   endtask

   task automatic test_random();
      int   last_win;
      int   outst [NM];
      bit   full;
      logic [9:0] exp_id;
      logic [7:0] exp_addr, exp_len;
      int   rm, win, cnt_list;
      int   live [$];
      logic [3:0] exp_ardy;

      apply_reset();
      last_win = NM - 1;
      full     = 1'b0;
      exp_id   = '0;
      exp_addr = '0;
      exp_len  = '0;
      foreach (outst[k]) outst[k] = 0;
      cnt_list = 0;

      for (int cyc = 0; cyc < 400; cyc++) begin
         total++; if (m_arvalid !== full ||
                      (full && (m_arid !== exp_id || m_araddr !== exp_addr || m_arlen !== exp_len))) begin
            bad++; $display("FAIL rand_ar cyc=%0d vld=%b id=%h addr=%h len=%h want vld=%b id=%h addr=%h len=%h",
                            cyc, m_arvalid, m_arid, m_araddr, m_arlen, full, exp_id, exp_addr, exp_len);
         end

         s_arvalid = 4'($urandom);
         s_araddr  = $urandom;
         s_arlen   = $urandom;
         s_arsize  = 12'($urandom);
         s_arburst = 8'($urandom);
         s_arid    = $urandom;
         m_arready = ($urandom_range(0, 3) != 0);
         s_rready  = 4'($urandom);

         live.delete();
         for (int k = 0; k < NM; k++) if (outst[k] > 0) live.push_back(k);
         rm = -1;
         if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
            rm       = live[$urandom_range(0, live.size() - 1)];
            m_rvalid = 1'b1;
            m_rid    = {2'(rm), 8'($urandom)};
            m_rlast  = ($urandom_range(0, 2) == 0);
            m_rdata  = 8'($urandom);
         end else begin
            m_rvalid = 1'b0;
            m_rid    = 10'($urandom);
            m_rlast  = 1'b0;
         end

         win = -1;
         if (!full || m_arready) begin
            for (int i = 1; i <= NM; i++) begin
               if (win < 0 && s_arvalid[(last_win + i) % NM] && outst[(last_win + i) % NM] < 4)
                  win = (last_win + i) % NM;
            end
         end
         exp_ardy = (win >= 0) ? 4'(1 << win) : 4'b0;

         #1;
         total++; if (s_arready !== exp_ardy) begin
            bad++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", cyc, s_arready, exp_ardy);
         end
         if (rm >= 0) begin
            total++; if (s_rvalid !== 4'(1 << rm) || m_rready !== s_rready[rm] || s_rid !== m_rid[7:0] || s_rdata !== m_rdata) begin
               bad++; $display("FAIL rand_route cyc=%0d rvalid=%b rready=%b rid=%h want rvalid=%b rready=%b rid=%h",
                               cyc, s_rvalid, m_rready, s_rid, 4'(1 << rm), s_rready[rm], m_rid[7:0]);
            end
         end else begin
            total++; if (s_rvalid !== 4'b0) begin
               bad++; $display("FAIL rand_route_idle cyc=%0d rvalid=%b want=0000", cyc, s_rvalid);
            end
         end

         if (rm >= 0 && s_rready[rm] && m_rlast) outst[rm]--;
         if (win >= 0) begin
            outst[win]++;
            last_win = win;
            full     = 1'b1;
            exp_id   = {2'(win), s_arid[win*8 +: 8]};
            exp_addr = s_araddr[win*8 +: 8];
            exp_len  = s_arlen[win*8 +: 8];
            cnt_list++;
         end else if (full && m_arready) begin
            full = 1'b0;
         end
         @(negedge aclk);
      end
      drive_idle();
      #1;
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rand_no_err got=%b want=0", rsp_err); end
      $display("random: 400 cycles, %0d grants", cnt_list);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_hold_stable();
      test_outst_limit();
      test_r_route();
      test_same_cycle();
      test_rsp_err_and_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
